id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
Parametrised instruction-decode stage for the 16-bit pipelined core. It decodes the fetched instruction, reads operands from an internal NREG-entry register file, and registers the results into an ID/EX pipeline register. It also detects load-use hazards (stall plus bubble), accepts flushes from branch resolution, and latches a halted state on HLT.

Parameters:
DW, 16, register/data width (8..32).
NREG, 16, register count (power of 2, 2..16); AW = log2(NREG).
IW, 16, instruction width; the field layout below assumes 16.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
if_valid  in  1  instruction valid from IF.
if_instr  in  IW  instruction; op=[15:12], rd=[11:8], rs1=[7:4], rs0=[3:0], imm8=[7:0].
id_ready  out  1  ID accepts if_instr this cycle.
flush  in  1  discard the current ID instruction and kill ex_valid next cycle.
wb_we  in  1  register-file write enable.
wb_addr  in  AW  write address.
wb_data  in  DW  write data.
ex_valid  out  1  ID/EX entry valid.
ex_p0, ex_p1  out  DW  operands (rs0, rs1).
ex_imm  out  DW  sign-extended imm8.
ex_alu_op  out  3  op[2:0].
ex_sh_amt  out  4  instr[3:0].
ex_src1_imm  out  1  select ex_imm as ALU source 1.
ex_dst  out  AW  destination register.
ex_we, ex_mem_rd, ex_mem_wr  out  1  control bits.
ex_branch  out  1  branch instruction.
ex_br_cond  out  3  instr[11:9].
halted  out  1  HLT has issued; the stage is frozen.

Behaviour:
- Decode table:
  - op 0000-0111: ALU, ex_we=1; ops 0101-0111 are shifts and use sh_amt; reads rs0 and rs1 (shifts read rs1 only).
  - 1000 LW: mem_rd, we, src1_imm, reads rs1.
  - 1001 SW: mem_wr, reads rs0 (data) and rs1.
  - 1010 LLI: we, src1_imm, no register reads.
  - 1100 B: branch, no writes.
  - 1111 HLT.
  - Other ops decode as NOP: valid, all controls 0.
- Register indices are truncated to AW bits. Register 0 always reads 0, and writes to it are ignored.
- Register file: registered write on the clk edge; combinational read.
- Accept condition: if_valid & id_ready & ~flush. On accept, the ID/EX register loads the decoded fields next edge with ex_valid=1. Otherwise ex_valid goes to 0 (bubble); the data fields may hold.
- Latency: 1 cycle from accept to ex_valid.
- State machine RUN / STALL / HALTED:
  - RUN: id_ready=1 unless a hazard is present.
  - Hazard: ex_valid & ex_mem_rd & ex_dst!=0 & ex_dst matches a source actually read by if_instr. On hazard, id_ready=0 combinationally, insert a bubble, and go to STALL.
  - STALL lasts exactly 1 cycle (the bubble clears the hazard): id_ready=1, then return to RUN.
  - HALTED: entered on the edge that accepts HLT. The HLT entry is issued with ex_valid=1. halted=1, id_ready=0 and ex_valid=0 thereafter. Left only by rst.
- flush has priority over hazard and accept. A flush in STALL returns to RUN with a bubble. A flush in HALTED has no effect.
- rst (asynchronous):
  - All ex_* outputs = 0, ex_valid=0, halted=0, state=RUN.
  - All registers = 0.
  - A reset mid-stall drops the stalled instruction.
- Simultaneous wb_we to a register being read: see BYPASS_EN.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: a read of wb_addr while wb_we=1 (addr!=0) returns wb_data in the same cycle (write-through).
- Undefined: the read returns the old contents; the new value is visible from the next cycle.

Test Plan:
1. Reset then idle -> ex_valid=0, halted=0, id_ready=1, and a read of any register gives 0.
2. wb_we addr3=0x1234; ALU instr 0x0213 (rd2, rs1=1, rs0=3) -> next cycle ex_p0=0x1234, ex_valid=1, ex_we=1, ex_alu_op=0.
3. LW 0x8410 then ADD 0x0524 reading r4 -> second cycle id_ready=0 with bubble (ex_valid=0); ADD issues the following cycle.
4. LLI 0xA6F0 -> ex_imm=0xFFF0, ex_src1_imm=1, ex_dst=6.
5. flush asserted with valid ADD -> next ex_valid=0, instruction discarded, id_ready=1.
6. HLT 0xF000 -> ex_valid=1 for one cycle, then halted=1, id_ready=0, and further instrs are ignored until rst.
7. wb_we r5=0xBEEF while reading r5 -> 0xBEEF with RF_BYPASS_EN, old 0 without it.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: decode, register-file read, load-use stall, flush, halt.
// Optional macro RF_BYPASS_EN makes a same-cycle register write visible to the read ports.
module id_stage_pipe #(
  parameter int DW   = 16,
  parameter int NREG = 16,
  parameter int IW   = 16,
  localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_valid,
  input  logic [IW-1:0] if_instr,
  output logic          id_ready,
  input  logic          flush,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          ex_valid,
  output logic [DW-1:0] ex_p0,
  output logic [DW-1:0] ex_p1,
  output logic [DW-1:0] ex_imm,
  output logic [2:0]    ex_alu_op,
  output logic [3:0]    ex_sh_amt,
  output logic          ex_src1_imm,
  output logic [AW-1:0] ex_dst,
  output logic          ex_we,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr,
  output logic          ex_branch,
  output logic [2:0]    ex_br_cond,
  output logic          halted
);

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LLI = 4'hA;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;

  state_t state;

  logic [DW-1:0] rf [NREG];

  logic [3:0]    op;
  logic [AW-1:0] rd_idx, rs1_idx, rs0_idx;
  logic [DW-1:0] imm_ext;
  logic          dec_we, dec_mem_rd, dec_mem_wr, dec_branch, dec_src1_imm;
  logic          use_rs0, use_rs1;
  logic [DW-1:0] p0_val, p1_val;
  logic          hazard, accept;

  assign op      = if_instr[IW-1 -: 4];
  assign rd_idx  = if_instr[8 +: AW];
  assign rs1_idx = if_instr[4 +: AW];
  assign rs0_idx = if_instr[0 +: AW];
  assign imm_ext = DW'($signed(if_instr[7:0]));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    dec_we       = 1'b0;
    dec_mem_rd   = 1'b0;
    dec_mem_wr   = 1'b0;
    dec_branch   = 1'b0;
    dec_src1_imm = 1'b0;
    use_rs0      = 1'b0;
    use_rs1      = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
        dec_we  = 1'b1;
        use_rs0 = 1'b1;
        use_rs1 = 1'b1;
      end
      4'h5, 4'h6, 4'h7: begin
        dec_we  = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_LW: begin
        dec_mem_rd   = 1'b1;
        dec_we       = 1'b1;
        dec_src1_imm = 1'b1;
        use_rs1      = 1'b1;
      end
      OP_SW: begin
        dec_mem_wr = 1'b1;
        use_rs0    = 1'b1;
        use_rs1    = 1'b1;
      end
      OP_LLI: begin
        dec_we       = 1'b1;
        dec_src1_imm = 1'b1;
      end
      OP_B: begin
        dec_branch = 1'b1;
        use_rs0    = 1'b1;
        use_rs1    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    p0_val = rf[rs0_idx];
    p1_val = rf[rs1_idx];
`ifdef RF_BYPASS_EN
    if (wb_we && (wb_addr != '0)) begin
      if (wb_addr == rs0_idx) p0_val = wb_data;
      if (wb_addr == rs1_idx) p1_val = wb_data;
    end
`endif
    if (rs0_idx == '0) p0_val = '0;
    if (rs1_idx == '0) p1_val = '0;
  end

  // Load-use: the load in EX has not produced its data yet.
  assign hazard = ex_valid && ex_mem_rd && (ex_dst != '0) &&
                  ((use_rs0 && (ex_dst == rs0_idx)) || (use_rs1 && (ex_dst == rs1_idx)));

  assign id_ready = ((state == RUN) && !hazard) || (state == STALL);
  assign accept   = if_valid && id_ready && !flush;

  // NOTE: the register file is reset like any other state, so its reset loop lives in always_ff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && (wb_addr != '0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      halted      <= 1'b0;
      ex_valid    <= 1'b0;
      ex_p0       <= '0;
      ex_p1       <= '0;
      ex_imm      <= '0;
      ex_alu_op   <= '0;
      ex_sh_amt   <= '0;
      ex_src1_imm <= 1'b0;
      ex_dst      <= '0;
      ex_we       <= 1'b0;
      ex_mem_rd   <= 1'b0;
      ex_mem_wr   <= 1'b0;
      ex_branch   <= 1'b0;
      ex_br_cond  <= '0;
    end else begin
      case (state)
        HALTED: ex_valid <= 1'b0;
        default: begin
          if (flush) begin
            ex_valid <= 1'b0;
            state    <= RUN;
          end else if ((state == RUN) && hazard) begin
            ex_valid <= 1'b0;
            state    <= STALL;
          end else if (accept) begin
            ex_valid    <= 1'b1;
            ex_p0       <= p0_val;
            ex_p1       <= p1_val;
            ex_imm      <= imm_ext;
            ex_alu_op   <= op[2:0];
            ex_sh_amt   <= if_instr[3:0];
            ex_src1_imm <= dec_src1_imm;
            ex_dst      <= rd_idx;
            ex_we       <= dec_we;
            ex_mem_rd   <= dec_mem_rd;
            ex_mem_wr   <= dec_mem_wr;
            ex_branch   <= dec_branch;
            ex_br_cond  <= if_instr[11:9];
            if (op == OP_HLT) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            ex_valid <= 1'b0;
            state    <= RUN;
          end
        end
      endcase
    end
  end

endmodule
